// File: rtl/keypad_scanner_if.sv
// Key-pad bus: matrix sense/drive lines plus the accepted-key result.
// Ports: keypad_row (rows, active-low), keypad_col (one column low at a time),
//        key_code / key_valid / key_held (accepted key towards the controller).
interface keypad_scanner_if;
  logic [3:0] keypad_row;
  logic [3:0] keypad_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  // Scanner side: senses rows, drives columns and the key result.
  modport master (
    input  keypad_row,
    output keypad_col,
    output key_code,
    output key_valid,
    output key_held
  );

  // Keypad/consumer side.
  modport slave (
    output keypad_row,
    input  keypad_col,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with frame-level debounce and ghost rejection.
// Latency: key_valid/key_held change 1 clk after the col-3 sample of the deciding frame.
// No back-pressure: the scan free-runs; key_valid is a one-cycle strobe.
// Ports: clk, reset (sync, active-high), kp (keypad_scanner_if.master):
//        keypad_row in, keypad_col out, key_code/key_valid/key_held out.
module keypad_scanner #(
  parameter int SCAN_TICKS = 1000,
  parameter int DEB_FRAMES = 4
) (
  input  logic             clk,
  input  logic             reset,
  keypad_scanner_if.master kp
);

  localparam int             DW         = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_TICKS - 1);
  localparam logic [7:0]     DEB_N      = 8'(DEB_FRAMES);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Scan / snapshot registers
  logic [3:0]    row_s1_q, row_s2_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_q, col_d;
  logic [15:0]   snap_q, snap_d;
  logic          eval_q, eval_d;
  logic          dwell_end;
  logic [3:0]    idx;

  // FSM registers
  state_e        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [7:0]    deb_q, deb_d;
  logic [7:0]    rel_q, rel_d;
  logic          accept, release_key;

  // Output registers
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;

  // Frame classification
  logic [4:0]    n_set;
  logic [3:0]    fr_code;
  logic          fr_none, fr_single;

  assign dwell_end = (dwell_q == DWELL_LAST);

  always_comb begin
    dwell_d = dwell_end ? '0 : dwell_q + DW'(1);
    col_d   = dwell_end ? col_q + 2'd1 : col_q;
    // The classification cycle follows the last column sample of a frame.
    eval_d  = dwell_end && (col_q == 2'd3);
    snap_d  = snap_q;
    idx     = '0;
    if (dwell_end) begin
      // Snapshot bit index equals the key code {row, col}; a low row means pressed.
      for (int r = 0; r < 4; r++) begin
        idx         = {2'(r), col_q};
        snap_d[idx] = ~row_s2_q[2'(r)];
      end
    end
  end

  always_comb begin
    n_set   = '0;
    fr_code = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap_q[4'(i)]) begin
        if (n_set == 5'd0) fr_code = 4'(i);
        n_set = n_set + 5'd1;
      end
    end
    fr_none   = (n_set == 5'd0);
    fr_single = (n_set == 5'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
      dwell_q  <= '0;
      col_q    <= '0;
      snap_q   <= '0;
      eval_q   <= 1'b0;
    end else begin
      row_s1_q <= kp.keypad_row;
      row_s2_q <= row_s1_q;
      dwell_q  <= dwell_d;
      col_q    <= col_d;
      snap_q   <= snap_d;
      eval_q   <= eval_d;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cand_q  <= '0;
      deb_q   <= '0;
      rel_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      deb_q   <= deb_d;
      rel_q   <= rel_d;
    end
  end

  // FSM: next state, only moves in the frame evaluation cycle
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    deb_d       = deb_q;
    rel_d       = rel_q;
    accept      = 1'b0;
    release_key = 1'b0;
    if (eval_q) begin
      case (state_q)
        IDLE: begin
          if (fr_single) begin
            cand_d = fr_code;
            if (DEB_N <= 8'd1) begin
              accept  = 1'b1;
              deb_d   = '0;
              state_d = PRESSED;
            end else begin
              deb_d   = 8'd1;
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (fr_single) begin
            if (fr_code == cand_q) begin
              deb_d = sat_inc(deb_q);
              if (deb_d >= DEB_N) begin
                accept  = 1'b1;
                deb_d   = '0;
                state_d = PRESSED;
              end
            end else begin
              cand_d = fr_code;
              deb_d  = 8'd1;
            end
          end else begin
            deb_d   = '0;
            state_d = IDLE;
          end
        end
        PRESSED: begin
          // Any activity (even another key) keeps the key pressed.
          if (fr_none) begin
            if (DEB_N <= 8'd1) begin
              release_key = 1'b1;
              rel_d       = '0;
              state_d     = IDLE;
            end else begin
              rel_d   = 8'd1;
              state_d = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (fr_none) begin
            rel_d = sat_inc(rel_q);
            if (rel_d >= DEB_N) begin
              release_key = 1'b1;
              rel_d       = '0;
              state_d     = IDLE;
            end
          end else begin
            rel_d   = '0;
            state_d = PRESSED;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    key_code_d  = accept ? cand_d : key_code_q;
    key_valid_d = accept;
    key_held_d  = key_held_q;
    if (accept)           key_held_d = 1'b1;
    else if (release_key) key_held_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign kp.keypad_col = ~(4'b0001 << col_q);
  assign kp.key_code   = key_code_q;
  assign kp.key_valid  = key_valid_q;
  assign kp.key_held   = key_held_q;

endmodule
